cpu_fetch_decode_seq: RTL

//  Fetch/decode sequencer upstream of the ALU/opcode execute stage. Fetches 16-bit words over an

---
 rtl/cpu_isa_pkg.sv | 57 +++++
 rtl/cpu_mul_wait_counter.sv | 32 +++
 rtl/cpu_fetch_decode_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg
// Opcode encodings, sequencer state encoding and opcode-class helpers shared
// by the fetch/decode sequencer and the execute stage.
package cpu_isa_pkg;

    localparam int OPCODE_W = 6;

    typedef logic [OPCODE_W-1:0] opcode_t;

    // Encoded opcodes as they appear in IR[15:10]
    localparam opcode_t OP_JMR     = 6'h00;
    localparam opcode_t OP_AIM     = 6'h0B;
    localparam opcode_t OP_SIM     = 6'h0C;
    localparam opcode_t OP_ADD     = 6'h11;
    localparam opcode_t OP_STORE   = 6'h19;
    localparam opcode_t OP_LOAD    = 6'h1A;
    localparam opcode_t OP_PUSH    = 6'h1B;
    localparam opcode_t OP_POP     = 6'h1C;
    localparam opcode_t OP_MUL     = 6'h21;
    localparam opcode_t OP_MLS     = 6'h22;
    localparam opcode_t OP_CALL    = 6'h24;
    localparam opcode_t OP_RTN     = 6'h26;
    localparam opcode_t OP_BRD     = 6'h38;

    // Highest legal encoding; anything above decodes as illegal
    localparam opcode_t OP_MAX     = 6'h38;
    localparam opcode_t OP_ILLEGAL = 6'h3F;

    // Sequencer phases
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC1  = 2'd2,
        ST_EXEC2  = 2'd3
    } seq_state_t;

    // Instructions that wait in EXEC2 for the data-memory handshake
    function automatic logic is_mem_op(input opcode_t op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_STORE, OP_LOAD, OP_PUSH, OP_POP, OP_CALL, OP_RTN: hit = 1'b1;
            default:                                             hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Instructions that spend a fixed number of cycles in EXEC2
    function automatic logic is_mul_op(input opcode_t op);
        return (op == OP_MUL) || (op == OP_MLS);
    endfunction

    function automatic logic is_illegal_op(input opcode_t op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/cpu_mul_wait_counter.sv
// cpu_mul_wait_counter
// Loadable down-counter that times the fixed-length EXEC2 phase of the
// multiply instructions. zero is high once the count has run out.
module cpu_mul_wait_counter
    import cpu_isa_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; the count saturates at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cpu_fetch_decode_seq.sv
// cpu_fetch_decode_seq
// Fetch/decode sequencer ahead of the execute stage. Fetches one 16-bit word
// per instruction over the imem handshake, decodes IR[15:10] into the latched
// opcode and produces the exec1/exec2 timing strobes. Owns the PC.
// Optional feature: define CPU_ILLEGAL_TRAP_EN to vector illegal opcodes to
// TRAP_VECTOR with a one-cycle trap pulse; otherwise they behave as NOPs.
module cpu_fetch_decode_seq
    import cpu_isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MUL_CYCLES  = 4,
    parameter logic [15:0] TRAP_VECTOR = 16'h0004
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        dmem_done,
    input  logic        skipstatus,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    output logic        skip_clr,
    output logic [15:0] instruction,
    output logic [5:0]  decoder_encoded_opcode,
    output logic        exec1,
    output logic        exec2,
    output logic        aim,
    output logic        sim,
    output logic [15:0] pc,
    output logic        trap
);

`ifdef CPU_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // The counter must be able to hold MUL_CYCLES; it is loaded with one
    // less so that zero marks the final EXEC2 cycle
    localparam int             CNT_W    = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    seq_state_t state;
    seq_state_t state_next;

    logic [15:0] ir;
    opcode_t     opcode;
    opcode_t     decode_op;
    logic        decode_illegal;
    logic        enter_exec2;
    logic        mul_dec;
    logic        mul_zero;

    assign decode_op      = ir[15:10];
    assign decode_illegal = is_illegal_op(decode_op);
    assign enter_exec2    = (state == ST_EXEC1) && (state_next == ST_EXEC2);
    assign mul_dec        = (state == ST_EXEC2) && is_mul_op(opcode);

    cpu_mul_wait_counter #(
        .WIDTH (CNT_W)
    ) u_mul_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (enter_exec2),
        .load_value (MUL_LOAD),
        .dec        (mul_dec),
        .zero       (mul_zero)
    );

    // Sequencer state register; reset always returns to FETCH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Phase transitions: squash and illegal both fall straight back to FETCH
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (skipstatus) begin
                    state_next = ST_FETCH;
                end else if (decode_illegal) begin
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                if (is_mem_op(opcode) || is_mul_op(opcode)) begin
                    state_next = ST_EXEC2;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_EXEC2: begin
                if (is_mul_op(opcode)) begin
                    if (mul_zero) begin
                        state_next = ST_FETCH;
                    end
                end else if (dmem_done) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Strobes are pure decodes of the current phase; the fetch request is
    // also held off while reset is asserted
    always_comb begin
        imem_req = 1'b0;
        skip_clr = 1'b0;
        exec1    = 1'b0;
        exec2    = 1'b0;
        aim      = 1'b0;
        sim      = 1'b0;
        trap     = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = rst_n;
            end
            ST_DECODE: begin
                skip_clr = skipstatus;
                trap     = TRAP_EN && !skipstatus && decode_illegal;
            end
            ST_EXEC1: begin
                exec1 = 1'b1;
                aim   = (opcode == OP_AIM);
                sim   = (opcode == OP_SIM);
            end
            ST_EXEC2: begin
                exec2 = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // PC, IR and latched opcode; each phase only touches what it owns
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ir     <= '0;
            opcode <= OP_JMR;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + 16'd1;
                    end
                end
                ST_DECODE: begin
                    if (skipstatus) begin
                        opcode <= decode_op;
                    end else if (decode_illegal) begin
                        opcode <= OP_ILLEGAL;
                        if (TRAP_EN) begin
                            pc <= TRAP_VECTOR;
                        end
                    end else begin
                        opcode <= decode_op;
                    end
                end
                ST_EXEC1: begin
                    if (pc_load) begin
                        pc <= pc_load_value;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr              = pc;
    assign instruction            = ir;
    assign decoder_encoded_opcode = opcode;

endmodule
